// File: rtl/conv_host_mem_responder.sv
// Host-side memory responder for the CONV accelerator: image + five layer banks, start handshake, run timer.
// Latency: all memory reads are combinational (same cycle); writes and loads land on the rising edge.
// Backpressure: none; ready is a level request held until busy is sampled high.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   ld_valid/ld_addr/ld_data image preload (accepted in IDLE and DONE only)
//   start, ready, busy      run handshake (ready registered, rises the cycle after start)
//   iaddr -> idata          image read for the accelerator
//   crd/cwr/csel/caddr_*/cdata_* layer-memory access (csel 1=L0K0 2=L0K1 3=L1K0 4=L1K1 5=L2)
//   dbg_sel/dbg_addr -> dbg_data independent read-back (dbg_sel 0 = image)
//   done, run_cycles, err   status (done sticky, run_cycles saturating, err sticky)
// Optional macro CONV_HOST_ACCESS_CHECK_EN builds the access checker driving err;
// without it err is tied low.
module conv_host_mem_responder #(
  parameter int IMG_DEPTH = 4096,
  parameter int L0_DEPTH  = 4096,
  parameter int L1_DEPTH  = 1024,
  parameter int L2_DEPTH  = 2048,
  parameter int DW        = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [11:0]   ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [11:0]   iaddr,
  output logic [DW-1:0] idata,
  input  logic          crd,
  input  logic          cwr,
  input  logic [11:0]   caddr_rd,
  input  logic [11:0]   caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic [2:0]    dbg_sel,
  input  logic [11:0]   dbg_addr,
  output logic [DW-1:0] dbg_data,
  output logic          done,
  output logic [31:0]   run_cycles,
  output logic          err
);

  localparam int IMG_AW = $clog2(IMG_DEPTH);
  localparam int L0_AW  = $clog2(L0_DEPTH);
  localparam int L1_AW  = $clog2(L1_DEPTH);
  localparam int L2_AW  = $clog2(L2_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [DW-1:0] img  [IMG_DEPTH];
  logic [DW-1:0] l0k0 [L0_DEPTH];
  logic [DW-1:0] l0k1 [L0_DEPTH];
  logic [DW-1:0] l1k0 [L1_DEPTH];
  logic [DW-1:0] l1k1 [L1_DEPTH];
  logic [DW-1:0] l2   [L2_DEPTH];

  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [31:0]   run_cycles_q, run_cycles_d;
  logic          start_acc;
  logic          ld_en;
  logic          wr_l0k0, wr_l0k1, wr_l1k0, wr_l1k1, wr_l2;

  function automatic logic in_rng(input logic [11:0] a, input int depth);
    return {20'd0, a} < 32'(depth);
  endfunction

  function automatic logic [DW-1:0] img_rd(input logic [11:0] a);
    img_rd = '0;
    if (in_rng(a, IMG_DEPTH)) img_rd = img[a[IMG_AW-1:0]];
  endfunction

  // Bank read with range check; any select outside 1..5 reads as zero.
  function automatic logic [DW-1:0] bank_rd(input logic [2:0] sel, input logic [11:0] a);
    bank_rd = '0;
    case (sel)
      3'd1: if (in_rng(a, L0_DEPTH)) bank_rd = l0k0[a[L0_AW-1:0]];
      3'd2: if (in_rng(a, L0_DEPTH)) bank_rd = l0k1[a[L0_AW-1:0]];
      3'd3: if (in_rng(a, L1_DEPTH)) bank_rd = l1k0[a[L1_AW-1:0]];
      3'd4: if (in_rng(a, L1_DEPTH)) bank_rd = l1k1[a[L1_AW-1:0]];
      3'd5: if (in_rng(a, L2_DEPTH)) bank_rd = l2[a[L2_AW-1:0]];
      default: bank_rd = '0;
    endcase
  endfunction

  // Start is only honoured when no run is pending or active.
  assign start_acc = start && (state_q == S_IDLE || state_q == S_DONE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  if (busy)  state_d = S_RUN;
      S_RUN:  if (!busy) state_d = S_DONE;
      S_DONE: if (start) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (next values of registered outputs) ----------------
  // run_cycles counts every cycle spent in RUN, including the cycle whose edge leaves it.
  always_comb begin
    ready_d      = (state_d == S_REQ);
    done_d       = (state_d == S_DONE);
    run_cycles_d = run_cycles_q;
    if (start_acc)
      run_cycles_d = '0;
    else if (state_q == S_RUN && run_cycles_q != 32'hFFFF_FFFF)
      run_cycles_d = run_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      ready_q      <= ready_d;
      done_q       <= done_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign run_cycles = run_cycles_q;

  // ---------------- memories (not reset; contents survive reset) ----------------
  assign ld_en   = ld_valid && (state_q == S_IDLE || state_q == S_DONE) && in_rng(ld_addr, IMG_DEPTH);
  assign wr_l0k0 = cwr && (csel == 3'd1) && in_rng(caddr_wr, L0_DEPTH);
  assign wr_l0k1 = cwr && (csel == 3'd2) && in_rng(caddr_wr, L0_DEPTH);
  assign wr_l1k0 = cwr && (csel == 3'd3) && in_rng(caddr_wr, L1_DEPTH);
  assign wr_l1k1 = cwr && (csel == 3'd4) && in_rng(caddr_wr, L1_DEPTH);
  assign wr_l2   = cwr && (csel == 3'd5) && in_rng(caddr_wr, L2_DEPTH);

  always_ff @(posedge clk) if (ld_en)   img[ld_addr[IMG_AW-1:0]]   <= ld_data;
  always_ff @(posedge clk) if (wr_l0k0) l0k0[caddr_wr[L0_AW-1:0]]  <= cdata_wr;
  always_ff @(posedge clk) if (wr_l0k1) l0k1[caddr_wr[L0_AW-1:0]]  <= cdata_wr;
  always_ff @(posedge clk) if (wr_l1k0) l1k0[caddr_wr[L1_AW-1:0]]  <= cdata_wr;
  always_ff @(posedge clk) if (wr_l1k1) l1k1[caddr_wr[L1_AW-1:0]]  <= cdata_wr;
  always_ff @(posedge clk) if (wr_l2)   l2[caddr_wr[L2_AW-1:0]]    <= cdata_wr;

  // Reads are combinational, so a same-address read during a write sees pre-edge data.
  assign idata    = img_rd(iaddr);
  assign cdata_rd = crd ? bank_rd(csel, caddr_rd) : '0;
  assign dbg_data = (dbg_sel == 3'd0) ? img_rd(dbg_addr) : bank_rd(dbg_sel, dbg_addr);

  // ---------------- optional access checker ----------------
`ifdef CONV_HOST_ACCESS_CHECK_EN
  logic err_q, saw_cwr_q, err_hit, csel_ok, active;

  function automatic int bank_depth(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: bank_depth = L0_DEPTH;
      3'd3, 3'd4: bank_depth = L1_DEPTH;
      3'd5:       bank_depth = L2_DEPTH;
      default:    bank_depth = 0;
    endcase
  endfunction

  assign csel_ok = (csel >= 3'd1) && (csel <= 3'd5);
  assign active  = (state_q == S_REQ) || (state_q == S_RUN);

  always_comb begin
    err_hit = 1'b0;
    if (active) begin
      if (crd && cwr)                                      err_hit = 1'b1;
      if ((crd || cwr) && !csel_ok)                        err_hit = 1'b1;
      if (crd && !in_rng(caddr_rd, bank_depth(csel)))      err_hit = 1'b1;
      if (cwr && !in_rng(caddr_wr, bank_depth(csel)))      err_hit = 1'b1;
      // A run that ends without ever writing results is suspicious.
      if (state_q == S_RUN && !busy && !(saw_cwr_q || cwr)) err_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q     <= 1'b0;
      saw_cwr_q <= 1'b0;
    end else if (start_acc) begin
      err_q     <= 1'b0;
      saw_cwr_q <= 1'b0;
    end else begin
      if (err_hit)                  err_q     <= 1'b1;
      if (state_q == S_RUN && cwr)  saw_cwr_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
